// File: rtl/nn_stream_upscaler_if.sv
// ---------------------------------------------------------------------------
// nn_stream_upscaler_if
// Bundles the input pixel stream (s_*) and output pixel stream (m_*) of
// nn_stream_upscaler into a single interface.
//   slave  : view taken by the upscaler (consumes s_*, produces m_*)
//   master : view taken by the surrounding logic (pixel source + writer)
// Signals:
//   s_data  [DATA_W] input pixel          s_valid  input pixel valid
//   s_ready          block accepts s_data m_data   [DATA_W] output pixel
//   m_valid          output pixel valid   m_ready  downstream accepts m_data
//   m_last           final output pixel of a frame
// ---------------------------------------------------------------------------
interface nn_stream_upscaler_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/nn_stream_upscaler.sv
// ---------------------------------------------------------------------------
// nn_stream_upscaler
// Nearest-neighbour upscaler for a raster grayscale pixel stream. Input rows
// are captured into a two-bank (ping-pong) line buffer; each buffered row is
// replayed SCALE_V times with every pixel repeated SCALE_H times.
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   bus (slave)     s_data/s_valid/s_ready input stream,
//                   m_data/m_valid/m_ready/m_last output stream (registered)
// Optional (macro UPS_FRAME_STATS_EN):
//   frame_done      one-cycle pulse after each m_last transfer
//   frame_cnt[16]   count of m_last transfers, wraps at 65535
// ---------------------------------------------------------------------------
module nn_stream_upscaler #(
  parameter int DATA_W  = 8,
  parameter int IMG_W   = 128,
  parameter int IMG_H   = 72,
  parameter int SCALE_H = 3,
  parameter int SCALE_V = 3
) (
  input  logic                clk,
  input  logic                rst,
  nn_stream_upscaler_if.slave bus
`ifdef UPS_FRAME_STATS_EN
  ,
  output logic                frame_done,
  output logic [15:0]         frame_cnt
`endif
);

  localparam int COL_W = (IMG_W   > 1) ? $clog2(IMG_W)   : 1;
  localparam int ROW_W = (IMG_H   > 1) ? $clog2(IMG_H)   : 1;
  localparam int HR_W  = (SCALE_H > 1) ? $clog2(SCALE_H) : 1;
  localparam int VR_W  = (SCALE_V > 1) ? $clog2(SCALE_V) : 1;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [HR_W-1:0]  LAST_HR  = HR_W'(SCALE_H - 1);
  localparam logic [VR_W-1:0]  LAST_VR  = VR_W'(SCALE_V - 1);

  typedef enum logic {ST_IDLE, ST_EMIT} state_e;

  // Line buffer
  logic [DATA_W-1:0] r_mem [2][IMG_W];
  logic [1:0]        r_full;

  // Write side
  logic              r_en;
  logic              r_wr_bank;
  logic [COL_W-1:0]  r_wr_col;
  logic              w_s_fire;
  logic              w_wr_row_end;

  // Read side
  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_rd_bank;
  logic [HR_W-1:0]   r_h_rep;
  logic [COL_W-1:0]  r_rd_col;
  logic [VR_W-1:0]   r_v_rep;
  logic [ROW_W-1:0]  r_rd_row;
  logic              w_load;
  logic              w_row_end;
  logic              w_frame_end;

  // Output register
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_valid;
  logic              r_m_last;

  // r_en keeps s_ready low until the first clock after reset release.
  assign bus.s_ready   = r_en && !r_full[r_wr_bank];
  assign w_s_fire      = bus.s_valid && bus.s_ready;
  assign w_wr_row_end  = w_s_fire && (r_wr_col == LAST_COL);

  assign bus.m_data    = r_m_data;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_last    = r_m_last;

  always_ff @(posedge clk) begin
    if (w_s_fire) r_mem[r_wr_bank][r_wr_col] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en      <= 1'b0;
      r_wr_bank <= 1'b0;
      r_wr_col  <= '0;
    end else begin
      r_en <= 1'b1;
      if (w_s_fire) begin
        if (r_wr_col == LAST_COL) begin
          r_wr_col  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_col <= r_wr_col + 1'b1;
        end
      end
    end
  end

  // Set and clear always target different banks: the write bank is never
  // full while being written, the read bank is full while being read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= '0;
    end else begin
      if (w_wr_row_end) r_full[r_wr_bank] <= 1'b1;
      if (w_row_end)    r_full[r_rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_row_end   = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_full[r_rd_bank]) w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        w_load      = !r_m_valid || bus.m_ready;
        w_row_end   = w_load && (r_h_rep == LAST_HR) && (r_rd_col == LAST_COL)
                      && (r_v_rep == LAST_VR);
        w_frame_end = w_row_end && (r_rd_row == LAST_ROW);
        // Continue straight into the other bank when it is already waiting.
        if (w_row_end && !r_full[~r_rd_bank]) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_bank <= 1'b0;
      r_h_rep   <= '0;
      r_rd_col  <= '0;
      r_v_rep   <= '0;
      r_rd_row  <= '0;
    end else if (w_load) begin
      if (r_h_rep != LAST_HR) begin
        r_h_rep <= r_h_rep + 1'b1;
      end else begin
        r_h_rep <= '0;
        if (r_rd_col != LAST_COL) begin
          r_rd_col <= r_rd_col + 1'b1;
        end else begin
          r_rd_col <= '0;
          if (r_v_rep != LAST_VR) begin
            r_v_rep <= r_v_rep + 1'b1;
          end else begin
            r_v_rep   <= '0;
            r_rd_bank <= ~r_rd_bank;
            if (r_rd_row != LAST_ROW) r_rd_row <= r_rd_row + 1'b1;
            else                      r_rd_row <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (!r_m_valid || bus.m_ready) begin
      r_m_valid <= w_load;
      r_m_last  <= w_frame_end;
      if (w_load) r_m_data <= r_mem[r_rd_bank][r_rd_col];
    end
  end

`ifdef UPS_FRAME_STATS_EN
  logic        r_frame_done;
  logic [15:0] r_frame_cnt;
  logic        w_last_xfer;

  assign w_last_xfer = r_m_valid && bus.m_ready && r_m_last;
  assign frame_done  = r_frame_done;
  assign frame_cnt   = r_frame_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_done <= w_last_xfer;
      if (w_last_xfer) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end
`endif

endmodule
